// File: rtl/clk_divider_pkg.sv
// Shared controller definitions used by the command interpreter and the
// core-clock divider.
//   mode_e : clock generation mode carried on the divider's `option` input
package clk_divider_pkg;

  typedef enum logic {
    MODE_PULSE = 1'b0,  // emit a programmed number of clk_o periods, then idle low
    MODE_AUTO  = 1'b1   // free-run clk_o while enabled
  } mode_e;

endpackage

// File: rtl/clk_divider.sv
// Gated, divided core clock generator for the processor under test.
// clk_o is a flop output toggled every H = max(divider,1) clk cycles while
// running, giving an exact 50% duty cycle at clk/(2H).
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   write_pulse  single-cycle strobe loading `pulse` into the remaining count
//   option       mode select (MODE_PULSE / MODE_AUTO)
//   out_enable   1 = generation allowed, 0 = clk_o forced low
//   divider      half-period length in clk cycles (0 treated as 1)
//   pulse        number of clk_o rising edges to emit in pulse mode
//   clk_o        divided core clock
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = 32,
  parameter int unsigned PULSE_BITS   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_pulse,
  input  logic                    option,
  input  logic                    out_enable,
  input  logic [COUNTER_BITS-1:0] divider,
  input  logic [PULSE_BITS-1:0]   pulse,
  output logic                    clk_o
);

  logic [COUNTER_BITS-1:0] r_half_cnt;
  logic [PULSE_BITS-1:0]   r_remaining;
  logic                    r_clk_o;

  logic [COUNTER_BITS-1:0] w_half_m1;
  logic                    w_auto;
  logic                    w_run;
  logic                    w_toggle;

  always_comb begin
    // H-1 with divider 0 treated as 1 collapses to divider-1 saturated at 0
    w_half_m1 = (divider == '0) ? '0 : divider - COUNTER_BITS'(1);
    w_auto    = (mode_e'(option) == MODE_AUTO);
    // A high phase in progress always runs to completion
    w_run     = out_enable && (w_auto || (r_remaining != '0) || r_clk_o);
    // >= rather than == so a divider reduced below the current count
    // toggles immediately instead of wrapping the counter
    w_toggle  = (r_half_cnt >= w_half_m1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_o     <= 1'b0;
      r_half_cnt  <= '0;
      r_remaining <= '0;
    end else begin
      if (!out_enable) begin
        r_clk_o    <= 1'b0;
        r_half_cnt <= '0;
      end else if (!w_run) begin
        r_clk_o    <= 1'b0;
        r_half_cnt <= '0;
      end else if (w_toggle) begin
        r_clk_o    <= ~r_clk_o;
        r_half_cnt <= '0;
        if (!r_clk_o && !w_auto) begin
          r_remaining <= r_remaining - PULSE_BITS'(1);
        end
      end else begin
        r_half_cnt <= r_half_cnt + COUNTER_BITS'(1);
      end

      // Later assignment wins: a new load overrides any same-cycle decrement
      if (write_pulse) begin
        r_remaining <= pulse;
      end
    end
  end

  assign clk_o = r_clk_o;

endmodule

// File: tb/tb_clk_divider.sv
module tb_clk_divider;

  localparam int CB = 8;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write_pulse = 1'b0;
  logic          option = 1'b0;
  logic          out_enable = 1'b0;
  logic [CB-1:0] divider = '0;
  logic [PB-1:0] pulse = '0;
  logic          clk_o;

  clk_divider #(.COUNTER_BITS(CB), .PULSE_BITS(PB)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_pulse(write_pulse),
    .option     (option),
    .out_enable (out_enable),
    .divider    (divider),
    .pulse      (pulse),
    .clk_o      (clk_o)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge of clk
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int   e;
    logic v;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  bit  mon_en = 0;
  logic prev = 1'b0;
  ev_t  mx;

  // Monitor: every clk_o transition must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en && (clk_o !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_edge: clk_o went %b at edge %0d, required no edge", clk_o, edge_n);
      end else begin
        mx = exp_q.pop_front();
        if (mx.e == edge_n && mx.v === clk_o) passed++;
        else $display("FAIL edge_timing: got clk_o=%b at edge %0d, required clk_o=%b at edge %0d",
                      clk_o, edge_n, mx.v, mx.e);
      end
    end
    prev = clk_o;
  end

  function automatic void push(int e, logic v);
    ev_t x;
    x.e = e;
    x.v = v;
    exp_q.push_back(x);
  endfunction

  // Reference: clk_o toggles on a regular grid first, first+h, ...; ntog toggles
  // starting from low. If cut>0, a forced-low event (reset / enable drop)
  // sampled at edge `cut` kills every toggle from cut onward and drops a high
  // level at cut. Returns the number of rising edges emitted.
  function automatic int plan(int first, int h, int ntog, int cut);
    int   rises = 0;
    logic lvl = 1'b0;
    for (int t = 0; t < ntog; t++) begin
      int et;
      et = first + t * h;
      if (cut > 0 && et >= cut) begin
        if (lvl) push(cut, 1'b0);
        return rises;
      end
      lvl = ~lvl;
      push(et, lvl);
      if (lvl) rises++;
    end
    if (cut > 0 && lvl) push(cut, 1'b0);
    return rises;
  endfunction

  function automatic int toggles_before(int first, int h, int cut);
    int m = 0;
    while (first + m * h < cut) m++;
    return m;
  endfunction

  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns with inputs about to be sampled at edge e
  task automatic go_to(int e);
    while (edge_n + 1 < e) step();
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      step();
      b++;
    end
    repeat (24) step();
    checks++;
    if (exp_q.size() == 0) passed++;
    else begin
      $display("FAIL drain: %0d expected edges never seen, required 0 (next at edge %0d)",
               exp_q.size(), exp_q[0].e);
      exp_q.delete();
    end
  endtask

  task automatic burst(int n, int d);
    int k, h, r;
    h = eff(d);
    divider = CB'(d);
    pulse = PB'(n);
    write_pulse = 1'b1;
    k = edge_n + 1;
    r = plan(k + h, h, 2 * n, 0);
    step();
    write_pulse = 1'b0;
    drain();
  endtask

  // Drop out_enable at edge k+eoff (random inside the burst if eoff<0)
  task automatic enable_drop(int n, int d, int eoff);
    int k, h, e, rr, rb, r2;
    h = eff(d);
    divider = CB'(d);
    pulse = PB'(n);
    write_pulse = 1'b1;
    k = edge_n + 1;
    e = (eoff >= 0) ? k + eoff : k + $urandom_range(2, 2 * n * h);
    rr = e + $urandom_range(1, 6);
    rb = plan(k + h, h, 2 * n, e);
    r2 = plan(rr + h - 1, h, 2 * (n - rb), 0);
    step();
    write_pulse = 1'b0;
    go_to(e);
    out_enable = 1'b0;
    go_to(rr);
    out_enable = 1'b1;
    drain();
  endtask

  // Reload during the high phase of rise number r of a running burst
  task automatic write_in_high(int n1, int r, int n2, int d);
    int k, h, a, w, x;
    h = eff(d);
    divider = CB'(d);
    pulse = PB'(n1);
    write_pulse = 1'b1;
    k = edge_n + 1;
    a = k + (2 * r - 1) * h;
    w = a + $urandom_range(1, h);
    x = plan(k + h, h, 2 * r + 2 * n2, 0);
    step();
    write_pulse = 1'b0;
    go_to(w);
    pulse = PB'(n2);
    write_pulse = 1'b1;
    step();
    write_pulse = 1'b0;
    drain();
  endtask

  // Preload n pulses while disabled, free-run in auto mode, then return to
  // pulse mode: the preloaded count must still be intact.
  task automatic auto_run(int d, int n);
    int h, j, c, m, x;
    h = eff(d);
    out_enable = 1'b0;
    pulse = PB'(n);
    write_pulse = 1'b1;
    step();
    write_pulse = 1'b0;
    divider = CB'(d);
    option = 1'b1;
    out_enable = 1'b1;
    j = edge_n + 1;
    c = j + $urandom_range(1, 30);
    m = toggles_before(j + h - 1, h, c);
    x = plan(j + h - 1, h, m + (m % 2) + 2 * n, 0);
    go_to(c);
    option = 1'b0;
    drain();
  endtask

  // Divider reduced from 8 to 2 once the half-period count has reached 5
  task automatic divider_shrink();
    int j, c, m, x;
    divider = CB'(8);
    option = 1'b1;
    j = edge_n + 1;
    c = j + 5 + $urandom_range(1, 20);
    m = toggles_before(j + 5, 2, c);
    x = plan(j + 5, 2, m + (m % 2), 0);
    go_to(j + 5);
    divider = CB'(2);
    go_to(c);
    option = 1'b0;
    drain();
  endtask

  task automatic reset_mid(int n, int d, int eoff);
    int k, h, e, x;
    h = eff(d);
    divider = CB'(d);
    pulse = PB'(n);
    write_pulse = 1'b1;
    k = edge_n + 1;
    e = (eoff >= 0) ? k + eoff : k + $urandom_range(2, 2 * n * h - 1);
    x = plan(k + h, h, 2 * n, e);
    step();
    write_pulse = 1'b0;
    go_to(e);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain();
    checks++;
    if (clk_o === 1'b0) passed++;
    else $display("FAIL post_reset_idle: clk_o=%b, required 0", clk_o);
  endtask

  initial begin
    repeat (3) step();
    checks++;
    if (clk_o === 1'b0) passed++;
    else $display("FAIL reset_state: clk_o=%b, required 0", clk_o);
    reset = 1'b0;
    out_enable = 1'b1;
    step();
    prev = clk_o;
    mon_en = 1;

    burst(3, 2);
    burst(0, 3);
    auto_run(0, 0);
    auto_run(1, 0);
    auto_run(3, 2);
    enable_drop(10, 2, 15);         // dropped in the high phase after rise 4
    write_in_high(3, 2, 5, 2);
    divider_shrink();
    reset_mid(10, 2, 11);           // reset once 3 of 10 rises are out
    burst(2, 1);

    for (int i = 0; i < 14; i++) begin
      int n, d;
      n = $urandom_range(1, 5);
      d = $urandom_range(0, 4);
      case ($urandom_range(0, 4))
        0: burst($urandom_range(0, 5), d);
        1: enable_drop(n, d, -1);
        2: write_in_high(n, $urandom_range(1, n), $urandom_range(0, 4), d);
        3: auto_run(d, $urandom_range(0, 3));
        default: reset_mid(n, d, -1);
      endcase
    end

    mon_en = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/clk_divider.md
# clk_divider

- Generates the gated, divided core clock `clk_o` for the processor under test from the controller system clock.
- Two modes:
  - pulse mode: emits an exact number of `clk_o` periods on command from the command interpreter, then holds `clk_o` low.
  - auto mode: free-runs `clk_o` continuously.
- Sits between the command interpreter (which programs the pulse count and enable) and the core clock input.

## Interface

Parameters:
- `COUNTER_BITS`, default 32: width of the divider value and the half-period counter.
- `PULSE_BITS`, default 32: width of the pulse count and the remaining-pulse counter.

Ports (reset: synchronous, active-high, named `reset`; clock: `clk`):
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous active-high reset.
- `write_pulse`  in  1  single-cycle strobe; loads `pulse` into the remaining-pulse counter.
- `option`  in  1  mode select: 0 = pulse mode, 1 = auto mode.
- `out_enable`  in  1  1 = clock generation allowed; 0 = `clk_o` forced low.
- `divider`  in  COUNTER_BITS  half-period length of `clk_o`, in `clk` cycles; 0 is treated as 1.
- `pulse`  in  PULSE_BITS  number of `clk_o` rising edges to emit; sampled only on `write_pulse`.
- `clk_o`  out  1  divided core clock; driven directly from a flop.

## Operation

Internal state:
- `half_cnt` (COUNTER_BITS): clk cycles elapsed in the current `clk_o` phase.
- `remaining` (PULSE_BITS): rising edges still owed in pulse mode.
- `clk_o` register.

Derived values:
- `H = (divider == 0) ? 1 : divider`.
- `run = out_enable && (option == 1 || remaining != 0 || clk_o == 1)`.

Per-edge behaviour, in priority order:
1. `reset`: `clk_o <= 0`, `half_cnt <= 0`, `remaining <= 0`.
2. `out_enable == 0`: `clk_o <= 0`, `half_cnt <= 0`. `remaining` is held, except that `write_pulse` still loads it.
3. `run == 0`: `half_cnt <= 0`, `clk_o` holds 0.
4. `run == 1`:
   - If `half_cnt >= H-1`: toggle `clk_o` and clear `half_cnt`.
   - Otherwise: increment `half_cnt`.
   - On a 0→1 toggle in pulse mode: `remaining <= remaining - 1`.

`write_pulse` handling:
- Sets `remaining <= pulse`; this overrides any decrement in the same cycle.
- Does not disturb `half_cnt` or `clk_o`.
- A high phase already in progress completes normally and is not counted. Exactly `pulse` new rising edges follow.

Mode behaviour:
- Auto mode ignores `remaining` and never decrements it.
- Switching from auto to pulse with `remaining == 0`: the current high phase completes, then `clk_o` stays low.

Additional rules:
- `divider` may change at any time and takes effect at the next compare. The `>=` compare keeps a reduced divider from causing a counter wrap.
- `clk_o` is never combinationally gated with `clk`; its transitions are glitch-free.

## Timing

- Reset values: `clk_o = 0`, `half_cnt = 0`, `remaining = 0`.
- `write_pulse` at edge k with `clk_o` low and `half_cnt = 0`:
  - first rise at edge k+H;
  - fall at edge k+2H;
  - the n-th rise at edge k+(2n-1)H.
  - After the N-th fall (edge k+2NH), `clk_o` stays low.
- `pulse = 0` on `write_pulse`: no edges are emitted.
- Maximum `clk_o` frequency is `clk`/2 (`H = 1`). Duty cycle is exactly 50%.
- `out_enable` falling: `clk_o` is low from the next edge, even mid high phase. This is a permitted truncation.
- `out_enable` rising with `remaining > 0` or auto mode: first rise H cycles later.
- Reset asserted mid-operation: all state is cleared on that edge, and `clk_o` is low from the next cycle.

## Structure

- Mode encodings `MODE_PULSE = 1'b0` and `MODE_AUTO = 1'b1` belong in the shared controller package, used by both the interpreter and this block.
- One flat module, no sub-modules: a single always block holds the counter, remaining-count and output registers.

## Test plan

- Reset, then `out_enable=1`, `option=0`, `divider=2`, `write_pulse` with `pulse=3` → exactly 3 rising edges on `clk_o`, 2 cycles high and 2 low each, first rise 2 cycles after the strobe; `clk_o` then stays 0.
- `option=1`, `divider=0` and `divider=1` → `clk_o` toggles every cycle (`clk`/2), continuous while `out_enable=1`; `remaining` is unchanged.
- Pulse mode with `pulse=10` running; drop `out_enable` after 4 rises → `clk_o` goes to 0 next edge; re-enable → 6 more rises, total 10.
- `write_pulse` with `pulse=5` during a high phase of a prior burst → that high phase completes, then exactly 5 further rises, then idle.
- `divider` changed from 8 to 2 while `half_cnt = 5` → toggle on the next edge, then 2-cycle half-periods, with no counter wrap.
- `reset` asserted mid-burst (`remaining = 7`) → `clk_o = 0` and no further edges after reset, until a new `write_pulse`.
